// File: rtl/m68k_bus_ctrl.sv
// m68k_bus_ctrl: 68000 bus-cycle controller placed after the address decoder.
// It latches the selected region at the start of each bus cycle, inserts the
// per-region wait states, waits for the SDRAM program-ROM fetch, and arbitrates
// the Z80/68000 shared RAM before driving a registered DTACK.
//
// Optional feature: define BUS_TIMEOUT_EN to add an 8-bit bus watchdog that
// forces DTACK after TIMEOUT clocks and raises a sticky bus_timeout flag.
//
// Ports:
//   clk                clock
//   reset              synchronous, active-high reset
//   cpu_as_n           68000 address strobe (active low)
//   prog_rom_cs        program ROM region select
//   ram_cs             work RAM region select
//   shared_ram_cs      Z80/68000 shared RAM region select
//   tile_palette_cs    tile palette select
//   sprite_palette_cs  sprite palette select
//   reg_cs             OR of all video/control register selects
//   prog_rom_ok        SDRAM data valid for the current ROM address
//   z80_shared_req     Z80 shared RAM request (level)
//   cpu_dtack_n        registered DTACK to the 68000 (active low)
//   z80_shared_gnt     registered shared RAM grant to the Z80
//   m68k_shared_own    68000 currently owns the shared RAM
//   bus_timeout        sticky watchdog flag (tied 0 without BUS_TIMEOUT_EN)
module m68k_bus_ctrl #(
  parameter int unsigned RAM_WAIT    = 0,
  parameter int unsigned SHARED_WAIT = 2,
  parameter int unsigned PAL_WAIT    = 1,
  parameter int unsigned REG_WAIT    = 1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_as_n,
  input  logic prog_rom_cs,
  input  logic ram_cs,
  input  logic shared_ram_cs,
  input  logic tile_palette_cs,
  input  logic sprite_palette_cs,
  input  logic reg_cs,
  input  logic prog_rom_ok,
  input  logic z80_shared_req,
  output logic cpu_dtack_n,
  output logic z80_shared_gnt,
  output logic m68k_shared_own,
  output logic bus_timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRom,
    StArb,
    StAck,
    StDisarmed
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       rom_first_q, rom_first_d;
  logic       dtack_n_q, dtack_n_d;
  logic       own_q, own_d;
  logic       gnt_q, gnt_d;
  logic       take_own;
  logic       wd_expired;

`ifdef BUS_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       timeout_q, timeout_d;
  logic       wd_counting;

  assign wd_counting = (state_q == StWait) || (state_q == StRom) || (state_q == StArb);
  assign wd_expired  = wd_counting && (wd_q == 8'(TIMEOUT));

  always_comb begin
    wd_d      = 8'd0;
    timeout_d = timeout_q | wd_expired;
    if (wd_counting && !wd_expired) begin
      wd_d = wd_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q      <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus_timeout = timeout_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^8'(TIMEOUT);
  assign wd_expired     = 1'b0;
  assign bus_timeout    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rom_first_d = 1'b0;
    dtack_n_d   = 1'b1;
    own_d       = own_q;
    take_own    = 1'b0;

    unique case (state_q)
      // Only leave reset once AS has been seen high, so a cycle that was in
      // flight across reset is never acknowledged.
      StDisarmed: begin
        if (cpu_as_n) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (!cpu_as_n) begin
          if (prog_rom_cs) begin
            state_d     = StRom;
            rom_first_d = 1'b1;
          end else if (ram_cs) begin
            state_d = StWait;
            count_d = 8'(RAM_WAIT);
          end else if (shared_ram_cs) begin
            state_d = StArb;
          end else if (tile_palette_cs || sprite_palette_cs) begin
            state_d = StWait;
            count_d = 8'(PAL_WAIT);
          end else if (reg_cs) begin
            state_d = StWait;
            count_d = 8'(REG_WAIT);
          end else begin
            state_d = StWait;
            count_d = 8'(REG_WAIT);
          end
        end
      end

      StWait: begin
        if (cpu_as_n) begin
          state_d = StIdle;
          own_d   = 1'b0;
        end else if (wd_expired || (count_q == 8'd0)) begin
          state_d = StAck;
        end else begin
          count_d = count_q - 8'd1;
        end
      end

      // The first clock in ROM ignores prog_rom_ok: it may still be the valid
      // flag left over from the previous fetch address.
      StRom: begin
        if (cpu_as_n) begin
          state_d = StIdle;
        end else if (wd_expired || (prog_rom_ok && !rom_first_q)) begin
          state_d = StAck;
        end
      end

      // A forced acknowledge from the watchdog never takes ownership.
      StArb: begin
        if (cpu_as_n) begin
          state_d = StIdle;
          own_d   = 1'b0;
        end else if (wd_expired) begin
          state_d = StAck;
        end else if (!gnt_q) begin
          take_own = 1'b1;
          own_d    = 1'b1;
          state_d  = StWait;
          count_d  = 8'(SHARED_WAIT);
        end
      end

      StAck: begin
        if (cpu_as_n) begin
          state_d = StIdle;
          own_d   = 1'b0;
        end else begin
          dtack_n_d = 1'b0;
        end
      end

      default: begin
        state_d = StDisarmed;
      end
    endcase

    // The Z80 keeps its grant while requesting, unless the 68000 owns the RAM
    // or is claiming it on this very edge.
    gnt_d = z80_shared_req && !own_q && !take_own;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StDisarmed;
      count_q     <= 8'd0;
      rom_first_q <= 1'b0;
      dtack_n_q   <= 1'b1;
      own_q       <= 1'b0;
      gnt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rom_first_q <= rom_first_d;
      dtack_n_q   <= dtack_n_d;
      own_q       <= own_d;
      gnt_q       <= gnt_d;
    end
  end

  assign cpu_dtack_n     = dtack_n_q;
  assign z80_shared_gnt  = gnt_q;
  assign m68k_shared_own = own_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Self-checking bench for m68k_bus_ctrl. A cycle-deadline model predicts the
// edge on which DTACK must fall for each bus cycle, plus grant/ownership, and a
// negedge process compares every output against it. Directed tests pin the
// model with hand-computed latencies.
module tb_m68k_bus_ctrl;

  localparam int RamWait    = 0;
  localparam int SharedWait = 2;
  localparam int PalWait    = 1;
  localparam int RegWait    = 1;
  localparam int Timeout    = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_as_n = 1'b1;
  logic prog_rom_cs = 1'b0;
  logic ram_cs = 1'b0;
  logic shared_ram_cs = 1'b0;
  logic tile_palette_cs = 1'b0;
  logic sprite_palette_cs = 1'b0;
  logic reg_cs = 1'b0;
  logic prog_rom_ok = 1'b0;
  logic z80_shared_req = 1'b0;
  logic cpu_dtack_n;
  logic z80_shared_gnt;
  logic m68k_shared_own;
  logic bus_timeout;

  m68k_bus_ctrl #(
    .RAM_WAIT   (RamWait),
    .SHARED_WAIT(SharedWait),
    .PAL_WAIT   (PalWait),
    .REG_WAIT   (RegWait),
    .TIMEOUT    (Timeout)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_as_n         (cpu_as_n),
    .prog_rom_cs      (prog_rom_cs),
    .ram_cs           (ram_cs),
    .shared_ram_cs    (shared_ram_cs),
    .tile_palette_cs  (tile_palette_cs),
    .sprite_palette_cs(sprite_palette_cs),
    .reg_cs           (reg_cs),
    .prog_rom_ok      (prog_rom_ok),
    .z80_shared_req   (z80_shared_req),
    .cpu_dtack_n      (cpu_dtack_n),
    .z80_shared_gnt   (z80_shared_gnt),
    .m68k_shared_own  (m68k_shared_own),
    .bus_timeout      (bus_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // Model: a bus cycle is described by its start edge and the edge on which
  // DTACK must fall (-1 while not yet known).
  bit m_armed = 1'b0;
  bit m_active = 1'b0;
  int m_kind = 0;  // 0 fixed wait, 1 ROM, 2 shared
  int m_start = 0;
  int m_dtack_edge = -1;
  bit m_arb_pending = 1'b0;
  bit m_dtack_n = 1'b1;
  bit m_gnt = 1'b0;
  bit m_own = 1'b0;
  bit m_to = 1'b0;

  always @(posedge clk) begin
    int e;
    bit take;
    bit own_old;
    cyc++;
    e = cyc;
    if (reset) begin
      m_armed   = 1'b0;
      m_active  = 1'b0;
      m_dtack_n = 1'b1;
      m_gnt     = 1'b0;
      m_own     = 1'b0;
      m_to      = 1'b0;
    end else begin
      own_old = m_own;
      take    = 1'b0;
      if (!m_armed) begin
        if (cpu_as_n) m_armed = 1'b1;
      end else if (!m_active) begin
        if (!cpu_as_n) begin
          m_active      = 1'b1;
          m_start       = e;
          m_kind        = 0;
          m_dtack_edge  = -1;
          m_arb_pending = 1'b0;
          if (prog_rom_cs) m_kind = 1;
          else if (ram_cs) m_dtack_edge = e + RamWait + 2;
          else if (shared_ram_cs) begin
            m_kind = 2;
            m_arb_pending = 1'b1;
          end else if (tile_palette_cs || sprite_palette_cs) m_dtack_edge = e + PalWait + 2;
          else m_dtack_edge = e + RegWait + 2;
        end
      end else begin
        if (cpu_as_n) begin
          m_active  = 1'b0;
          m_own     = 1'b0;
          m_dtack_n = 1'b1;
        end else begin
`ifdef BUS_TIMEOUT_EN
          if ((m_dtack_edge < 0 || e < m_dtack_edge) && e == m_start + Timeout + 1) begin
            m_to          = 1'b1;
            m_dtack_edge  = e + 1;
            m_arb_pending = 1'b0;
          end
`endif
          if (m_kind == 1 && m_dtack_edge < 0 && e >= m_start + 2 && prog_rom_ok)
            m_dtack_edge = e + 1;
          if (m_arb_pending && !m_gnt) begin
            m_arb_pending = 1'b0;
            m_own         = 1'b1;
            take          = 1'b1;
            m_dtack_edge  = e + SharedWait + 2;
          end
          m_dtack_n = !(m_dtack_edge >= 0 && e >= m_dtack_edge);
        end
      end
      m_gnt = z80_shared_req && !own_old && !take;
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_bit("model_dtack_n", cpu_dtack_n, m_dtack_n);
      check_bit("model_gnt", z80_shared_gnt, m_gnt);
      check_bit("model_own", m68k_shared_own, m_own);
      check_bit("model_timeout", bus_timeout, m_to);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_cs();
    prog_rom_cs       = 1'b0;
    ram_cs            = 1'b0;
    shared_ram_cs     = 1'b0;
    tile_palette_cs   = 1'b0;
    sprite_palette_cs = 1'b0;
    reg_cs            = 1'b0;
  endtask

  // sel: 0 rom, 1 ram, 2 shared, 3 tile pal, 4 sprite pal, 5 reg, 6 none,
  // 7 ram+shared (priority).
  task automatic start_cycle(input int sel, output int t0);
    clear_cs();
    case (sel)
      0: prog_rom_cs = 1'b1;
      1: ram_cs = 1'b1;
      2: shared_ram_cs = 1'b1;
      3: tile_palette_cs = 1'b1;
      4: sprite_palette_cs = 1'b1;
      5: reg_cs = 1'b1;
      7: begin
        ram_cs = 1'b1;
        shared_ram_cs = 1'b1;
      end
      default: ;
    endcase
    cpu_as_n = 1'b0;
    t0 = cyc + 1;
  endtask

  task automatic wait_dtack(input int budget, output int edge_no);
    edge_no = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cpu_dtack_n == 1'b0) begin
        edge_no = cyc;
        break;
      end
    end
  endtask

  task automatic end_cycle();
    cpu_as_n = 1'b1;
    clear_cs();
    tick();
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit at edge %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int t0;
    int ed;
    int lows;
    int exp_lat[5];
    int sels[5];

    tick();
    cmp_en = 1'b1;
    tick();
    check_bit("reset_dtack_n", cpu_dtack_n, 1'b1);
    check_bit("reset_gnt", z80_shared_gnt, 1'b0);
    check_bit("reset_own", m68k_shared_own, 1'b0);
    check_bit("reset_timeout", bus_timeout, 1'b0);
    reset = 1'b0;
    tick();
    tick();

    // Work RAM: DTACK two edges after AS is first sampled low.
    start_cycle(1, t0);
    wait_dtack(20, ed);
    check_int("ram_latency", ed - t0, 2);
    while (cyc < t0 + 4) tick();
    check_bit("ram_dtack_held", cpu_dtack_n, 1'b0);
    cpu_as_n = 1'b1;
    tick();
    check_bit("ram_dtack_rise", cpu_dtack_n, 1'b1);
    end_cycle();

    // Fixed-wait regions, including unmapped and the ram-over-shared priority.
    sels = '{3, 4, 5, 6, 7};
    exp_lat = '{PalWait + 2, PalWait + 2, RegWait + 2, 3, RamWait + 2};
    for (int i = 0; i < 5; i++) begin
      start_cycle(sels[i], t0);
      wait_dtack(20, ed);
      check_int($sformatf("region%0d_latency", sels[i]), ed - t0, exp_lat[i]);
      end_cycle();
    end

    // ROM with a stale valid: ok high through edge t0+1, low until t0+7.
    prog_rom_ok = 1'b1;
    start_cycle(0, t0);
    ed = -1;
    for (int i = 0; i < 30; i++) begin
      prog_rom_ok = ((cyc + 1) <= t0 + 1) || ((cyc + 1) >= t0 + 7);
      tick();
      if (!cpu_dtack_n) begin
        ed = cyc;
        break;
      end
    end
    check_int("rom_latency", ed - t0, 8);
    end_cycle();
    prog_rom_ok = 1'b0;

    // Shared RAM, uncontended.
    start_cycle(2, t0);
    wait_dtack(20, ed);
    check_int("shared_latency", ed - t0, SharedWait + 3);
    check_bit("shared_own_during_ack", m68k_shared_own, 1'b1);
    end_cycle();
    check_bit("shared_own_released", m68k_shared_own, 1'b0);

    // Contention: Z80 holds the grant, releases so its drop is sampled at t0+10.
    z80_shared_req = 1'b1;
    tick();
    tick();
    check_bit("z80_grant_held", z80_shared_gnt, 1'b1);
    start_cycle(2, t0);
    while (cyc < t0 + 9) tick();
    z80_shared_req = 1'b0;
    tick();
    check_bit("contend_own_not_yet", m68k_shared_own, 1'b0);
    tick();
    check_bit("contend_own_edge11", m68k_shared_own, 1'b1);
    z80_shared_req = 1'b1;
    wait_dtack(20, ed);
    check_int("contend_dtack_edge", ed - t0, 11 + SharedWait + 2);
    check_bit("rereq_not_granted", z80_shared_gnt, 1'b0);
    cpu_as_n = 1'b1;
    clear_cs();
    tick();
    check_bit("rereq_gnt_at_as_rise", z80_shared_gnt, 1'b0);
    tick();
    check_bit("rereq_gnt_after", z80_shared_gnt, 1'b1);
    z80_shared_req = 1'b0;
    tick();
    tick();

    // Tie: Z80 request sampled on the same edge the 68000 enters ARB; then
    // the 68000 abandons the cycle.
    start_cycle(2, t0);
    z80_shared_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_bit("tie_z80_wins", z80_shared_gnt, 1'b1);
    check_bit("tie_no_own", m68k_shared_own, 1'b0);
    cpu_as_n = 1'b1;
    z80_shared_req = 1'b0;
    clear_cs();
    tick();
    check_bit("tie_abandon_dtack", cpu_dtack_n, 1'b1);
    tick();
    tick();

    // Abandoned ROM cycle, then a fresh RAM cycle.
    start_cycle(0, t0);
    for (int i = 0; i < 4; i++) tick();
    cpu_as_n = 1'b1;
    clear_cs();
    tick();
    check_bit("rom_abandon_dtack", cpu_dtack_n, 1'b1);
    start_cycle(1, t0);
    wait_dtack(20, ed);
    check_int("after_abandon_latency", ed - t0, 2);

    // Reset during ACK with AS held low.
    reset = 1'b1;
    tick();
    check_bit("midreset_dtack_n", cpu_dtack_n, 1'b1);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!cpu_dtack_n) lows++;
    end
    check_int("disarmed_no_dtack", lows, 0);
    cpu_as_n = 1'b1;
    tick();
    start_cycle(1, t0);
    wait_dtack(20, ed);
    check_int("rearmed_latency", ed - t0, 2);
    end_cycle();

`ifdef BUS_TIMEOUT_EN
    prog_rom_ok = 1'b0;
    start_cycle(0, t0);
    wait_dtack(Timeout + 40, ed);
    check_int("timeout_latency", ed - t0, Timeout + 2);
    check_bit("timeout_flag", bus_timeout, 1'b1);
    end_cycle();
    start_cycle(1, t0);
    wait_dtack(20, ed);
    end_cycle();
    check_bit("timeout_sticky", bus_timeout, 1'b1);
`else
    prog_rom_ok = 1'b0;
    start_cycle(0, t0);
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!cpu_dtack_n) lows++;
    end
    check_int("no_timeout_dtack", lows, 0);
    check_bit("no_timeout_flag", bus_timeout, 1'b0);
    end_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
